// File: rtl/sprite_layer_mux.sv
// sprite_layer_mux: NUM_LAYERS movable rectangular sprite layers composited over
// a background pixel. Geometry is shadowed at frame start. The pipeline is two
// stages: window/opaque tests, then priority select. A per-frame collision flag
// reports player (layer 0) overlap with any other layer.

// Per-layer window and colour-key test, purely combinational.
module sprite_layer_win #(
    parameter int                    COORD_W = 10,
    parameter int                    COLOR_W = 8,
    parameter logic [3*COLOR_W-1:0]  KEY_RGB = 24'hFF00FF
) (
    input  logic                   en,
    input  logic [COORD_W-1:0]     x,
    input  logic [COORD_W-1:0]     y,
    input  logic [COORD_W-1:0]     px,
    input  logic [COORD_W-1:0]     py,
    input  logic [COORD_W-1:0]     pw,
    input  logic [COORD_W-1:0]     ph,
    input  logic [3*COLOR_W-1:0]   rgb,
    output logic                   hit,
    output logic                   opaque
);
    // One extra bit so a window near the right/bottom edge never wraps to 0.
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    assign x_end  = {1'b0, px} + {1'b0, pw};
    assign y_end  = {1'b0, py} + {1'b0, ph};
    assign hit    = en && (x >= px) && ({1'b0, x} < x_end)
                       && (y >= py) && ({1'b0, y} < y_end);
    assign opaque = (rgb != KEY_RGB);
endmodule

module sprite_layer_mux #(
    parameter int                    NUM_LAYERS = 8,
    parameter int                    COORD_W    = 10,
    parameter int                    COLOR_W    = 8,
    parameter logic [3*COLOR_W-1:0]  KEY_RGB    = 24'hFF00FF,
    localparam int                   IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_start,
    input  logic                              pix_valid_i,
    input  logic [COORD_W-1:0]                x,
    input  logic [COORD_W-1:0]                y,
    input  logic [NUM_LAYERS-1:0]             layer_en,
    input  logic [NUM_LAYERS*COORD_W-1:0]     layer_x,
    input  logic [NUM_LAYERS*COORD_W-1:0]     layer_y,
    input  logic [NUM_LAYERS*COORD_W-1:0]     layer_w,
    input  logic [NUM_LAYERS*COORD_W-1:0]     layer_h,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb,
    input  logic [3*COLOR_W-1:0]              bg_rgb,
    output logic [COLOR_W-1:0]                r,
    output logic [COLOR_W-1:0]                g,
    output logic [COLOR_W-1:0]                b,
    output logic                              pix_valid_o,
    output logic                              hit_any,
    output logic [IDX_W-1:0]                  hit_layer,
    output logic                              collision
);
    localparam int RGB_W  = 3*COLOR_W;
    localparam int STAGES = 2;

    // Shadow geometry, only refreshed on frame_start.
    logic [NUM_LAYERS-1:0]              sh_en_q, sh_en_d;
    logic [NUM_LAYERS-1:0][COORD_W-1:0] sh_x_q, sh_x_d;
    logic [NUM_LAYERS-1:0][COORD_W-1:0] sh_y_q, sh_y_d;
    logic [NUM_LAYERS-1:0][COORD_W-1:0] sh_w_q, sh_w_d;
    logic [NUM_LAYERS-1:0][COORD_W-1:0] sh_h_q, sh_h_d;

    // Stage 1 registers.
    logic [NUM_LAYERS-1:0]              s1_hit_q, s1_hit_d;
    logic [NUM_LAYERS-1:0]              s1_opq_q, s1_opq_d;
    logic [NUM_LAYERS-1:0][RGB_W-1:0]   s1_rgb_q, s1_rgb_d;
    logic [RGB_W-1:0]                   s1_bg_q, s1_bg_d;
    logic [STAGES:1]                    vld_pipe_q, vld_pipe_d;

    // Stage 2 (output) registers.
    logic [RGB_W-1:0]                   out_rgb_q, out_rgb_d;
    logic                               hit_any_q, hit_any_d;
    logic [IDX_W-1:0]                   hit_layer_q, hit_layer_d;

    // Collision tracking.
    logic                               coll_acc_q, coll_acc_d;
    logic                               collision_q, collision_d;

    logic [NUM_LAYERS-1:0][RGB_W-1:0]   lrgb;
    logic [NUM_LAYERS-1:0]              win_hit;
    logic [NUM_LAYERS-1:0]              win_opq;
    logic [NUM_LAYERS-1:0]              vis;
    logic                               coll_cond;

    assign lrgb = layer_rgb;

    // Per-layer tests always use the shadow geometry, never the live inputs.
    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        sprite_layer_win #(
            .COORD_W (COORD_W),
            .COLOR_W (COLOR_W),
            .KEY_RGB (KEY_RGB)
        ) u_win (
            .en     (sh_en_q[i]),
            .x      (x),
            .y      (y),
            .px     (sh_x_q[i]),
            .py     (sh_y_q[i]),
            .pw     (sh_w_q[i]),
            .ph     (sh_h_q[i]),
            .rgb    (lrgb[i]),
            .hit    (win_hit[i]),
            .opaque (win_opq[i])
        );
    end

    // Shadow capture and stage 1 next-state.
    always_comb begin
        sh_en_d    = frame_start ? layer_en : sh_en_q;
        sh_x_d     = frame_start ? layer_x  : sh_x_q;
        sh_y_d     = frame_start ? layer_y  : sh_y_q;
        sh_w_d     = frame_start ? layer_w  : sh_w_q;
        sh_h_d     = frame_start ? layer_h  : sh_h_q;
        s1_hit_d   = win_hit;
        s1_opq_d   = win_opq;
        s1_rgb_d   = lrgb;
        s1_bg_d    = bg_rgb;
        vld_pipe_d = {vld_pipe_q[STAGES-1:1], pix_valid_i};
    end

    // Stage 2: lowest visible layer index wins, otherwise background.
    always_comb begin
        vis         = s1_hit_q & s1_opq_q;
        out_rgb_d   = s1_bg_q;
        hit_any_d   = 1'b0;
        hit_layer_d = '0;
        for (int i = NUM_LAYERS-1; i >= 0; i--) begin
            if (vis[i]) begin
                out_rgb_d   = s1_rgb_q[i];
                hit_any_d   = 1'b1;
                hit_layer_d = IDX_W'(i);
            end
        end
    end

    // Collision: the pixel currently in stage 2 counts toward this frame even
    // when frame_start closes the frame on the same edge.
    always_comb begin
        coll_cond   = vld_pipe_q[1] && vis[0] && (|(vis >> 1));
        coll_acc_d  = coll_acc_q | coll_cond;
        collision_d = collision_q;
        if (frame_start) begin
            collision_d = coll_acc_q | coll_cond;
            coll_acc_d  = 1'b0;
        end
    end

    // All state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en_q     <= '0;
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            sh_w_q      <= '0;
            sh_h_q      <= '0;
            s1_hit_q    <= '0;
            s1_opq_q    <= '0;
            s1_rgb_q    <= '0;
            s1_bg_q     <= '0;
            vld_pipe_q  <= '0;
            out_rgb_q   <= '0;
            hit_any_q   <= 1'b0;
            hit_layer_q <= '0;
            coll_acc_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            sh_en_q     <= sh_en_d;
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            sh_w_q      <= sh_w_d;
            sh_h_q      <= sh_h_d;
            s1_hit_q    <= s1_hit_d;
            s1_opq_q    <= s1_opq_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_bg_q     <= s1_bg_d;
            vld_pipe_q  <= vld_pipe_d;
            out_rgb_q   <= out_rgb_d;
            hit_any_q   <= hit_any_d;
            hit_layer_q <= hit_layer_d;
            coll_acc_q  <= coll_acc_d;
            collision_q <= collision_d;
        end
    end

    assign r           = out_rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign g           = out_rgb_q[2*COLOR_W-1:COLOR_W];
    assign b           = out_rgb_q[COLOR_W-1:0];
    assign pix_valid_o = vld_pipe_q[STAGES];
    assign hit_any     = hit_any_q;
    assign hit_layer   = hit_layer_q;
    assign collision   = collision_q;
endmodule

// File: tb/tb_sprite_layer_mux.sv
// Directed bench for sprite_layer_mux: expected pixels are queued when driven
// and compared when they leave the two-stage pipeline.
module tb_sprite_layer_mux;
    localparam int N  = 8;
    localparam int CW = 10;
    localparam logic [23:0] KEY = 24'hFF00FF;
    localparam logic [23:0] BG  = 24'h0000FF;
    localparam logic [23:0] C0  = 24'hFFFF00;
    localparam logic [23:0] C1  = 24'h00FF00;
    localparam logic [23:0] C2  = 24'h00FFFF;
    localparam logic [23:0] C4  = 24'h445566;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic            pix_valid_i = 1'b0;
    logic [CW-1:0]   x = '0;
    logic [CW-1:0]   y = '0;
    logic [N-1:0]    layer_en = '0;
    logic [N*CW-1:0] layer_x = '0, layer_y = '0, layer_w = '0, layer_h = '0;
    logic [N*24-1:0] layer_rgb = {N{KEY}};
    logic [23:0]     bg_rgb = BG;
    logic [7:0]      r, g, b;
    logic            pix_valid_o, hit_any, collision;
    logic [2:0]      hit_layer;

    typedef struct {
        logic        vld;
        logic [23:0] rgb;
        logic        hit;
        logic [2:0]  idx;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    sprite_layer_mux dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid_i(pix_valid_i),
        .x(x), .y(y), .layer_en(layer_en), .layer_x(layer_x), .layer_y(layer_y),
        .layer_w(layer_w), .layer_h(layer_h), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
        .r(r), .g(g), .b(b), .pix_valid_o(pix_valid_o), .hit_any(hit_any),
        .hit_layer(hit_layer), .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic setl(input int i, input logic en, input logic [CW-1:0] px, py, pw, ph);
        layer_en[i]          = en;
        layer_x[i*CW +: CW]  = px;
        layer_y[i*CW +: CW]  = py;
        layer_w[i*CW +: CW]  = pw;
        layer_h[i*CW +: CW]  = ph;
    endtask

    task automatic setc(input int i, input logic [23:0] c);
        layer_rgb[i*24 +: 24] = c;
    endtask

    // Drive one pixel for one clock; check the pixel that leaves the pipeline.
    task automatic cyc(input logic v, input logic [CW-1:0] px, py,
                       input logic [23:0] e_rgb, input logic e_hit,
                       input logic [2:0] e_idx, input string tag);
        exp_t e;
        pix_valid_i = v;
        x = px;
        y = py;
        e.vld = v; e.rgb = e_rgb; e.hit = e_hit; e.idx = e_idx; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "/vld"}, {31'd0, pix_valid_o}, {31'd0, e.vld});
        if (e.vld) begin
            chk({e.tag, "/rgb"}, {8'd0, r, g, b}, {8'd0, e.rgb});
            chk({e.tag, "/hit"}, {31'd0, hit_any}, {31'd0, e.hit});
            chk({e.tag, "/idx"}, {29'd0, hit_layer}, {29'd0, e.idx});
        end
        pix_valid_i = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fs(input logic e_coll, input string tag);
        frame_start = 1'b1;
        cyc(1'b0, '0, '0, '0, 1'b0, 3'd0, {tag, "_fs"});
        chk(tag, {31'd0, collision}, {31'd0, e_coll});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "/rgb"}, {8'd0, r, g, b}, 32'd0);
        chk({tag, "/vld"}, {31'd0, pix_valid_o}, 32'd0);
        chk({tag, "/hit"}, {31'd0, hit_any}, 32'd0);
        chk({tag, "/idx"}, {29'd0, hit_layer}, 32'd0);
        chk({tag, "/coll"}, {31'd0, collision}, 32'd0);
    endtask

    initial begin
        exp_t d;
        d.vld = 1'b0; d.rgb = '0; d.hit = 1'b0; d.idx = '0; d.tag = "empty";

        repeat (3) @(posedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.push_back(d);

        // Frame A: layer 0 alone, edges of its window.
        setl(0, 1'b1, 304, 336, 32, 16);
        setc(0, C0);
        fs(1'b0, "coll_init");
        cyc(1'b1, 304, 336, C0, 1'b1, 3'd0, "l0_hit");
        cyc(1'b1, 336, 336, BG, 1'b0, 3'd0, "l0_xend");
        cyc(1'b1, 303, 336, BG, 1'b0, 3'd0, "l0_xlo");
        cyc(1'b1, 335, 351, C0, 1'b1, 3'd0, "l0_corner");
        cyc(1'b1, 304, 352, BG, 1'b0, 3'd0, "l0_yend");

        // Frame B: layers 0 and 1 overlap; priority and colour key.
        setl(1, 1'b1, 300, 330, 40, 40);
        setc(1, C1);
        fs(1'b0, "coll_A");
        cyc(1'b1, 310, 340, C0, 1'b1, 3'd0, "prio0");
        setc(0, KEY);
        cyc(1'b1, 310, 340, C1, 1'b1, 3'd1, "prio1_key");
        setc(0, C0);
        setc(1, KEY);

        // Frame C: geometry change without frame_start has no effect yet.
        fs(1'b1, "coll_B");
        setl(0, 1'b1, 400, 336, 32, 16);
        setl(2, 1'b1, 400, 336, 8, 8);
        setc(2, C2);
        cyc(1'b1, 304, 336, C0, 1'b1, 3'd0, "mid_old");

        // Frame D: new geometry live; layer 0 over layer 2 collides.
        fs(1'b0, "coll_C");
        cyc(1'b1, 304, 336, BG, 1'b0, 3'd0, "mid_miss");
        cyc(1'b1, 400, 336, C0, 1'b1, 3'd0, "mid_new");
        setc(0, KEY);
        cyc(1'b1, 401, 337, C2, 1'b1, 3'd2, "l2_under");
        setc(0, C0);

        // Frame E: only an invalid overlap pixel, so no collision.
        fs(1'b1, "coll_D");
        cyc(1'b1, 420, 340, C0, 1'b1, 3'd0, "l0_only");
        cyc(1'b0, 400, 336, C0, 1'b1, 3'd0, "inv_ovl");

        // Frame F: overlap pixel reaches stage 2 on the frame_start edge.
        fs(1'b0, "coll_E");
        cyc(1'b1, 400, 336, C0, 1'b1, 3'd0, "edge_px");
        setl(3, 1'b1, 0, 0, 0, 10);
        setl(4, 1'b1, 1020, 0, 10, 10);
        setc(3, 24'h112233);
        setc(4, C4);
        fs(1'b1, "coll_edge");
        fs(1'b0, "coll_clr");

        // Frame H: zero-width layer and right-edge layer never wrap.
        cyc(1'b1, 0, 0, BG, 1'b0, 3'd0, "w0_x0");
        cyc(1'b1, 1, 0, BG, 1'b0, 3'd0, "wrap_x1");
        cyc(1'b1, 2, 5, BG, 1'b0, 3'd0, "wrap_x2");
        cyc(1'b1, 3, 9, BG, 1'b0, 3'd0, "wrap_x3");
        cyc(1'b1, 1020, 0, C4, 1'b1, 3'd4, "edge_in");
        cyc(1'b1, 1023, 9, C4, 1'b1, 3'd4, "edge_last");
        cyc(1'b1, 1023, 10, BG, 1'b0, 3'd0, "edge_yend");
        cyc(1'b1, 400, 336, C0, 1'b1, 3'd0, "ovl_H");
        fs(1'b1, "coll_H");

        // Reset mid-frame with the pipeline full.
        cyc(1'b1, 1021, 0, C4, 1'b1, 3'd4, "pre_rst_a");
        cyc(1'b1, 1021, 1, C4, 1'b1, 3'd4, "pre_rst_b");
        chk("pre_rst_live", {31'd0, pix_valid_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.push_back(d);
        cyc(1'b1, 1021, 0, BG, 1'b0, 3'd0, "post_rst_l4");
        cyc(1'b1, 400, 336, BG, 1'b0, 3'd0, "post_rst_l0");
        cyc(1'b0, 0, 0, BG, 1'b0, 3'd0, "flush0");
        cyc(1'b0, 0, 0, BG, 1'b0, 3'd0, "flush1");
        chk("post_rst_coll", {31'd0, collision}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sprite_layer_mux.md
# sprite_layer_mux

Parametrised, pipelined pixel compositor for the VGA path. It replaces fixed-position sprite muxing with NUM_LAYERS movable rectangular layers, each with a runtime position, size and enable. Layer geometry is double-buffered and takes effect only at frame start. Each layer supports a transparency key, priority is fixed by layer index, and a per-frame collision flag between layer 0 (player) and all other layers is reported to the game logic. The block sits between the sprite ROM units and the RGB outputs of the VGA driver.

## Interface
Parameters:
- NUM_LAYERS, 8: number of sprite layers. Layer 0 has the highest priority.
- COORD_W, 10: width of the pixel coordinates and of the layer position/size fields.
- COLOR_W, 8: bits per colour channel.
- KEY_RGB, 24'hFF00FF: transparent colour key, {r,g,b}, 3*COLOR_W bits.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pix_valid_i  in  1  x/y/colour inputs valid this cycle
- x, y  in  COORD_W  current pixel coordinate
- layer_en  in  NUM_LAYERS  per-layer enable
- layer_x, layer_y  in  NUM_LAYERS*COORD_W  layer top-left corner, packed, layer i at [i*COORD_W +: COORD_W]
- layer_w, layer_h  in  NUM_LAYERS*COORD_W  layer size in pixels, packed
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  layer colour for the current x,y, {r,g,b} per layer, same cycle as x,y
- bg_rgb  in  3*COLOR_W  background colour (block repeater output), same cycle as x,y
- r, g, b  out  COLOR_W each  composited pixel
- pix_valid_o  out  1  r/g/b valid
- hit_any  out  1  some layer is visible at this pixel
- hit_layer  out  $clog2(NUM_LAYERS)  index of the visible layer; 0 when hit_any=0
- collision  out  1  layer 0 overlapped an opaque pixel of another layer during the previous frame

## Operation
- Shadow geometry registers: layer_en/x/y/w/h are captured into shadow registers only on cycles where frame_start=1. All window compares use the shadows. Changing the inputs mid-frame has no visible effect until the next frame_start.
- Window test for layer i: shadow_en[i] && x >= px && x < px+w && y >= py && y < py+h. Sums are computed COORD_W+1 bits wide, so there is no wrap. w=0 or h=0 means the layer is never visible.
- Opaque test: layer_rgb[i] != KEY_RGB.
- A layer is visible when it passes both the window test and the opaque test.
- Selection: the visible layer with the lowest index wins. If no layer is visible, output bg_rgb with hit_any=0 and hit_layer=0.
- Collision accumulator coll_acc:
  - Set when a pixel has pix_valid, layer 0 visible, and any layer 1..N-1 visible.
  - On frame_start: collision <= coll_acc | (collision condition for the pixel in the final stage that cycle), and coll_acc <= 0.
- When pix_valid is low, that pixel does not update coll_acc, and its outputs are don't-care apart from pix_valid_o=0.

## Timing
- Two-stage pipeline, latency 2 cycles from x/y/layer_rgb/bg_rgb/pix_valid_i to r/g/b/hit_*/pix_valid_o. Throughput is 1 pixel per cycle with no stalls.
- Stage 1 registers:
  - window-hit vector, using the shadows current in that cycle
  - opaque vector
  - layer colours
  - bg_rgb
  - pix_valid
- Stage 2 does the priority select and registers all outputs.
- Geometry latched by frame_start at edge k is used by pixels sampled at edge k+1 onward.
- collision updates only at frame_start edges and holds for a full frame.
- Reset values:
  - all shadows 0, so all layers disabled
  - r, g, b = 0
  - pix_valid_o = 0, hit_any = 0, hit_layer = 0
  - coll_acc = 0, collision = 0
  - pipeline valid bits cleared
- Reset asserted mid-frame clears everything immediately. Geometry stays disabled until the next frame_start.

## Test plan
- Reset, then frame_start with layer 0 at (304,336), size 32x16, enabled, opaque colour 24'hFFFF00, bg 24'h0000FF. Pixel (304,336): output FFFF00, hit_layer=0, two cycles later. Pixels (336,336) and (303,336): output 0000FF, hit_any=0.
- Layers 0 and 1 overlap at (310,340), both opaque. Layer 0's colour wins. Set layer 0's colour to FF00FF at that pixel: layer 1's colour is output, hit_layer=1.
- Layer x changed from 304 to 400 mid-frame without frame_start: pixel (304,336) still hits. After frame_start, pixel (304,336) misses and pixel (400,336) hits.
- Overlap of opaque layer 0 and layer 2 during frame N: collision=1 after the next frame_start. A frame with no overlap: collision=0 after the following frame_start. An overlap pixel in stage 2 on the same cycle as frame_start: collision=1.
- Layer with w=0, and a layer at x=1020 with w=10 and COORD_W=10: never hits at x=0..3 (no wrap). pix_valid_i=0 pixels: pix_valid_o=0 and no collision contribution.
- Assert rst_n low mid-frame with layers active: all outputs 0 at once. After release, only bg is output until a frame_start.
